// File: rtl/sbox_bram_pkg.sv
// Shared definitions for the S-box table loader.
//   - state_e: loader FSM states (IDLE, LOAD, VERIFY, CHECK)
//   - DEFAULT_AW / DEFAULT_DW / DEFAULT_RD_LAT: default BRAM geometry
//   - rotl1: one-bit circular left rotate inside a w-bit field. This is the
//     step of the rotate-XOR table checksum, so any model of the checksum
//     can call the same function.
package sbox_bram_pkg;

  localparam int DEFAULT_AW     = 10;
  localparam int DEFAULT_DW     = 8;
  localparam int DEFAULT_RD_LAT = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    VERIFY = 2'd2,
    CHECK  = 2'd3
  } state_e;

  // Rotates the low w bits of v left by one. Bits above w come back as zero.
  // w must lie in 1..63.
  function automatic logic [63:0] rotl1(input logic [63:0] v, input int w);
    logic [63:0] mask;
    mask  = (64'd1 << w) - 64'd1;
    rotl1 = ((v << 1) | (v >> (w - 1))) & mask;
  endfunction

endpackage

// File: rtl/bram_table_loader_if.sv
// Bus bundle for bram_table_loader: the byte input stream (valid/ready)
// together with one BRAM port.
//   master: the loader side. It drives in_ready and the BRAM port controls.
//   slave : the environment side. It drives the stream and BRAM read data.
interface bram_table_loader_if
  import sbox_bram_pkg::*;
#(
  parameter int AW = DEFAULT_AW,
  parameter int DW = DEFAULT_DW
);

  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic          bram_en;
  logic          bram_we;
  logic [AW-1:0] bram_addr;
  logic [DW-1:0] bram_din;
  logic [DW-1:0] bram_dout;

  modport master (
    input  in_data, in_valid, bram_dout,
    output in_ready, bram_en, bram_we, bram_addr, bram_din
  );

  modport slave (
    output in_data, in_valid, bram_dout,
    input  in_ready, bram_en, bram_we, bram_addr, bram_din
  );

endinterface

// File: rtl/bram_table_loader_chk.sv
// rot_xor_chk: DW-wide rotate-XOR checksum accumulator.
// Ports:
//   clk, rst : clock and synchronous active-high reset (clears the sum)
//   clr      : synchronous clear. It takes priority over en.
//   en       : fold din into the sum: chk <= rotl1(chk) ^ din
//   din      : byte to fold in
//   chk      : current checksum
module rot_xor_chk
  import sbox_bram_pkg::*;
#(
  parameter int DW = DEFAULT_DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          en,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] chk
);

  logic [DW-1:0] chk_q, chk_d;

  always_comb begin
    chk_d = chk_q;
    if (clr) begin
      chk_d = '0;
    end else if (en) begin
      chk_d = DW'(rotl1(64'(chk_q), DW)) ^ din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      chk_q <= '0;
    end else begin
      chk_q <= chk_d;
    end
  end

  assign chk = chk_q;

endmodule

// File: rtl/bram_table_loader.sv
// bram_table_loader: runtime writer and verifier for one masked S-box BRAM.
// It accepts DEPTH bytes over a valid/ready stream and writes them to
// consecutive addresses from 0. It then reads the whole table back through
// the same port and compares a rotate-XOR checksum of the readback against
// the checksum taken during the load.
// Ports:
//   clk, rst : single rising-edge clock, synchronous active-high reset
//   start    : begin a load. It is only looked at in IDLE.
//   bus      : master side of bram_table_loader_if. It carries the byte
//              stream (in_data/in_valid/in_ready) and the BRAM port
//              (bram_en/we/addr/din registered, bram_dout returned).
//   busy     : high while loading or verifying
//   done     : one-cycle pulse when the verify completes
//   error    : checksum mismatch. It holds until the next accepted start.
module bram_table_loader
  import sbox_bram_pkg::*;
#(
  parameter int AW     = DEFAULT_AW,
  parameter int DW     = DEFAULT_DW,
  parameter int DEPTH  = 1024,
  parameter int RD_LAT = DEFAULT_RD_LAT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  bram_table_loader_if.master bus,
  output logic                busy,
  output logic                done,
  output logic                error
);

  if (DEPTH < 1 || DEPTH > (1 << AW)) begin : g_bad_depth
    $error("bram_table_loader: DEPTH must be in 1..2**AW");
  end
  if (RD_LAT < 1) begin : g_bad_lat
    $error("bram_table_loader: RD_LAT must be at least 1");
  end

  localparam logic [1:0] S_IDLE   = IDLE;
  localparam logic [1:0] S_LOAD   = LOAD;
  localparam logic [1:0] S_VERIFY = VERIFY;
  localparam logic [1:0] S_CHECK  = CHECK;

  // Counters carry one extra bit so that DEPTH == 2**AW is reachable
  // without wrapping.
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW:0] LAST_C  = (AW+1)'(DEPTH - 1);

  logic [1:0]        state_q, state_d;
  logic [AW:0]       wr_cnt_q, wr_cnt_d;
  logic [AW:0]       rd_cnt_q, rd_cnt_d;
  logic [AW:0]       ret_cnt_q, ret_cnt_d;
  logic              en_q, en_d;
  logic              we_q, we_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic [DW-1:0]     din_q, din_d;
  logic              error_q, error_d;
  logic [RD_LAT-1:0] vld_q, vld_d;

  logic          in_ready;
  logic          hs;
  logic          rd_pres;
  logic          ret_vld;
  logic          chk_clr;
  logic [DW-1:0] chk_w, chk_r;

  // in_ready depends only on the state, so the source may wait on it freely.
  assign in_ready = (state_q == S_LOAD);
  assign hs       = bus.in_valid & in_ready;

  // A read address is on the port this cycle. Its data comes back on
  // bram_dout RD_LAT cycles later, and that is when it leaves the vld shift
  // register.
  assign rd_pres  = en_q & ~we_q & (state_q == S_VERIFY);
  assign ret_vld  = vld_q[RD_LAT-1] & (state_q == S_VERIFY);
  assign chk_clr  = (state_q == S_IDLE) & start;

  always_comb begin
    state_d   = state_q;
    wr_cnt_d  = wr_cnt_q;
    rd_cnt_d  = rd_cnt_q;
    ret_cnt_d = ret_cnt_q;
    en_d      = 1'b0;
    we_d      = 1'b0;
    addr_d    = addr_q;
    din_d     = din_q;
    error_d   = error_q;

    vld_d    = vld_q;
    vld_d[0] = rd_pres;
    for (int i = 1; i < RD_LAT; i++) begin
      vld_d[i] = vld_q[i-1];
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_LOAD;
          wr_cnt_d  = '0;
          rd_cnt_d  = '0;
          ret_cnt_d = '0;
          error_d   = 1'b0;
        end
      end
      S_LOAD: begin
        // A cycle with no handshake leaves en/we low, so gaps stall cleanly.
        if (hs) begin
          en_d     = 1'b1;
          we_d     = 1'b1;
          addr_d   = wr_cnt_q[AW-1:0];
          din_d    = bus.in_data;
          wr_cnt_d = wr_cnt_q + 1'b1;
          if (wr_cnt_q == LAST_C) begin
            state_d = S_VERIFY;
          end
        end
      end
      S_VERIFY: begin
        // The last write is on the port during the first VERIFY cycle. The
        // first read follows it, so a read and a write never share a cycle.
        if (rd_cnt_q < DEPTH_C) begin
          en_d     = 1'b1;
          addr_d   = rd_cnt_q[AW-1:0];
          rd_cnt_d = rd_cnt_q + 1'b1;
        end
        if (ret_vld) begin
          ret_cnt_d = ret_cnt_q + 1'b1;
        end
        if (ret_cnt_q == DEPTH_C) begin
          state_d = S_CHECK;
        end
      end
      default: begin
        error_d = (chk_r != chk_w);
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      wr_cnt_q  <= '0;
      rd_cnt_q  <= '0;
      ret_cnt_q <= '0;
      en_q      <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      din_q     <= '0;
      error_q   <= 1'b0;
      vld_q     <= '0;
    end else begin
      state_q   <= state_d;
      wr_cnt_q  <= wr_cnt_d;
      rd_cnt_q  <= rd_cnt_d;
      ret_cnt_q <= ret_cnt_d;
      en_q      <= en_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      din_q     <= din_d;
      error_q   <= error_d;
      vld_q     <= vld_d;
    end
  end

  rot_xor_chk #(.DW(DW)) u_chk_w (
    .clk (clk),
    .rst (rst),
    .clr (chk_clr),
    .en  (hs),
    .din (bus.in_data),
    .chk (chk_w)
  );

  rot_xor_chk #(.DW(DW)) u_chk_r (
    .clk (clk),
    .rst (rst),
    .clr (chk_clr),
    .en  (ret_vld),
    .din (bus.bram_dout),
    .chk (chk_r)
  );

  assign bus.in_ready  = in_ready;
  assign bus.bram_en   = en_q;
  assign bus.bram_we   = we_q;
  assign bus.bram_addr = addr_q;
  assign bus.bram_din  = din_q;

  assign busy  = (state_q == S_LOAD) | (state_q == S_VERIFY);
  assign done  = (state_q == S_CHECK);
  assign error = error_q;

endmodule
